// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver.
// Segment bit order is {g,f,e,d,c,b,a}; patterns are active-high.
package seg_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        DIG_U = 2'd0,
        DIG_D = 2'd1,
        DIG_C = 2'd2
    } dig_e;

    function automatic dig_e next_dig(input dig_e cur);
        case (cur)
            DIG_U:   return DIG_D;
            DIG_D:   return DIG_C;
            default: return DIG_U;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Three-digit multiplexed seven-segment driver with frame-synchronous
// double buffering and leading-zero blanking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          ACTIVE_LOW  = 1'b1,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] u,
    input  logic [3:0] d,
    input  logic [3:0] c,
    input  logic       load,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_done
);

    localparam int unsigned   CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [6:0]    SEG_OFF = ACTIVE_LOW ? '1 : '0;
    localparam logic [2:0]    AN_OFF  = ACTIVE_LOW ? '1 : '0;

    logic [CW-1:0] cnt_q, cnt_d;
    dig_e          idx_q, idx_d;
    logic [11:0]   shadow_q, shadow_d;
    logic [11:0]   active_q, active_d;
    logic          pending_q, pending_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;
    logic          frame_done_q, frame_done_d;

    logic       tick, boundary;
    logic [3:0] cur_bcd;
    logic       cur_blank;
    logic [6:0] pattern;
    logic [2:0] an_hot;

    assign tick     = (cnt_q == CNT_MAX);
    assign boundary = tick && (idx_q == DIG_C);

    bcd_to_seg u_dec (
        .bcd_i  (cur_bcd),
        .blank_i(cur_blank),
        .seg_o  (pattern)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= DIG_U;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        cnt_d        = tick ? '0 : cnt_q + CW'(1);
        idx_d        = tick ? next_dig(idx_q) : idx_q;
        frame_done_d = boundary;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;

        if (load) begin
            shadow_d  = {c, d, u};
            pending_d = 1'b1;
        end
        // A load landing on the boundary edge bypasses the shadow straight into active.
        if (boundary) begin
            if (load) begin
                active_d  = {c, d, u};
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end
    end

    always_comb begin
        cur_bcd   = active_q[3:0];
        cur_blank = 1'b0;
        case (idx_q)
            DIG_D: begin
                cur_bcd   = active_q[7:4];
                cur_blank = LZ_BLANK && (active_q[11:8] == 4'd0) && (active_q[7:4] == 4'd0);
            end
            DIG_C: begin
                cur_bcd   = active_q[11:8];
                cur_blank = LZ_BLANK && (active_q[11:8] == 4'd0);
            end
            default: begin
                cur_bcd   = active_q[3:0];
                cur_blank = 1'b0;
            end
        endcase

        an_hot = 3'b001 << idx_q;
        seg_d  = ACTIVE_LOW ? ~pattern : pattern;
        an_d   = ACTIVE_LOW ? ~an_hot : an_hot;
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule
